conv_core_kxk: RTL and testbench



---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_mult_su.sv | 22 ++
 rtl/conv_core_kxk.sv | 141 ++++++++++++++
 tb/tb_conv_core_kxk.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared defaults and elaboration helpers for the KxK convolution MAC core.
package conv_pkg;

  localparam int DEF_K      = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;

  // Depth of a binary reduction over n leaves, i.e. ceil(log2(n)); 0 for n=1.
  function automatic int tree_depth(input int n);
    int d;
    d = 0;
    while ((1 << d) < n) d++;
    return d;
  endfunction

  // Narrowest accumulator that holds a full single-beat sum without loss.
  function automatic int min_acc_w(input int data_w, input int k);
    return 2 * data_w + tree_depth(k * k);
  endfunction

  localparam int DEF_MIN_ACC_W = min_acc_w(DEF_DATA_W, DEF_K);

endpackage

// File: rtl/conv_mult_su.sv
// DATA_W x DATA_W multiplier with a per-operation signed/unsigned mode.
module conv_mult_su #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                signed_mode,
  output logic [2*DATA_W-1:0] product
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  // Extend both operands to the product width (sign or zero by mode); the
  // low 2*DATA_W bits of the wide product are then exact in either mode.
  always_comb begin
    a_ext   = {{DATA_W{signed_mode & a[DATA_W-1]}}, a};
    b_ext   = {{DATA_W{signed_mode & b[DATA_W-1]}}, b};
    product = a_ext * b_ext;
  end

endmodule

// File: rtl/conv_core_kxk.sv
// KxK convolution MAC core: operand register, K*K multipliers, adder tree and
// cross-channel accumulator, three stages, one global stall.
// Optional build macro: CONV_CORE_RELU_EN clamps negative signed results to 0
// at the output load (accumulator itself is never clamped).
module conv_core_kxk
  import conv_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W*K*K-1:0]   image,
  input  logic [DATA_W*K*K-1:0]   filter,
  input  logic                    first,
  input  logic                    last,
  input  logic                    signed_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        conv_out
);

  localparam int N         = K * K;
  localparam int PW        = 2 * DATA_W;
  localparam int MIN_ACC_W = min_acc_w(DATA_W, K);

  if (K < 1) begin : g_bad_k
    $error("conv_core_kxk: K must be at least 1");
  end
  if (ACC_W < MIN_ACC_W) begin : g_bad_acc_w
    $error("conv_core_kxk: ACC_W too narrow for K and DATA_W");
  end

  logic                  adv;
  logic                  s1_valid, s1_first, s1_last, s1_mode;
  logic [DATA_W*N-1:0]   s1_image, s1_filter;
  logic [PW-1:0]         prod [N];
  logic                  s2_valid, s2_first, s2_last, s2_mode;
  logic [PW-1:0]         s2_prod [N];
  logic [ACC_W-1:0]      node [1:2*N-1];
  logic [ACC_W-1:0]      sum, new_acc, out_next, acc;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: capture the accepted beat; bubbles enter as s1_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_mode   <= 1'b0;
      s1_image  <= '0;
      s1_filter <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_first  <= first;
        s1_last   <= last;
        s1_mode   <= signed_mode;
        s1_image  <= image;
        s1_filter <= filter;
      end
    end
  end

  // One multiplier per window element; element 0 sits in the top slice.
  for (genvar g = 0; g < N; g++) begin : g_mult
    conv_mult_su #(.DATA_W(DATA_W)) u_mult (
      .a           (s1_image[(N-1-g)*DATA_W +: DATA_W]),
      .b           (s1_filter[(N-1-g)*DATA_W +: DATA_W]),
      .signed_mode (s1_mode),
      .product     (prod[g])
    );
  end

  // S2: register the products together with the beat's control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_mode  <= 1'b0;
      for (int i = 0; i < N; i++) s2_prod[i] <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_mode  <= s1_mode;
        for (int i = 0; i < N; i++) s2_prod[i] <= prod[i];
      end
    end
  end

  // Heap-ordered binary adder tree: leaves at N..2N-1, root at node 1.
  always_comb begin
    for (int i = 1; i < 2 * N; i++) node[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (s2_mode) node[N+i] = ACC_W'(signed'(s2_prod[i]));
      else         node[N+i] = ACC_W'(s2_prod[i]);
    end
    for (int i = N - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
  end

  assign sum     = node[1];
  assign new_acc = (s2_first ? '0 : acc) + sum;

`ifdef CONV_CORE_RELU_EN
  // Negative signed results are presented downstream as zero.
  always_comb begin
    out_next = new_acc;
    if (s2_mode && new_acc[ACC_W-1]) out_next = '0;
  end
`else
  assign out_next = new_acc;
`endif

  // S3: accumulate across channels; on the last channel publish and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      conv_out  <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          conv_out <= out_next;
          acc      <= '0;
        end else begin
          acc <= new_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_core_kxk.sv
// Self-checking bench for conv_core_kxk: directed literal cases plus random
// traffic checked against a per-pixel arithmetic model.
module tb_conv_core_kxk;

  localparam int K  = 3;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int N  = K * K;
  localparam int VW = DW * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] image;
  logic [VW-1:0] filter;
  logic          first;
  logic          last;
  logic          signed_mode;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] conv_out;

  int tests_run    = 0;
  int tests_failed = 0;

  bit rand_ready = 1'b0;
  bit ready_cmd  = 1'b1;

  logic [AW-1:0] exp_q [$];
  longint        m_acc;
  bit            prev_hold = 1'b0;
  logic [AW-1:0] prev_data = '0;

  conv_core_kxk #(.K(K), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .image       (image),
    .filter      (filter),
    .first       (first),
    .last        (last),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .conv_out    (conv_out)
  );

  always #5 clk = ~clk;

  // Downstream readiness: either scripted or randomly throttled.
  always begin
    @(posedge clk);
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
  end

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // Dot product of one window with its filter, as plain integers.
  function automatic longint beatSum(input logic [VW-1:0] img, input logic [VW-1:0] flt,
                                     input logic mode);
    longint s;
    longint a;
    longint b;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    s = 0;
    for (int i = 0; i < N; i++) begin
      ea = img[i*DW +: DW];
      eb = flt[i*DW +: DW];
      a  = mode ? longint'($signed(ea)) : longint'(ea);
      b  = mode ? longint'($signed(eb)) : longint'(eb);
      s += a * b;
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: every accepted beat updates a per-pixel running sum.
  always @(posedge clk or negedge rst_n) begin
    logic [AW-1:0] r;
    longint        s;
    if (!rst_n) begin
      m_acc = 0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      s     = beatSum(image, filter, signed_mode);
      m_acc = (first ? s : m_acc + s) & ((64'd1 << AW) - 1);
      if (last) begin
        r = m_acc[AW-1:0];
`ifdef CONV_CORE_RELU_EN
        if (signed_mode && r[AW-1]) r = '0;
`endif
        exp_q.push_back(r);
        m_acc = 0;
      end
    end
  end

  // Per-cycle comparison of handshake rules and transferred results.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      checkOutput("in_ready", in_ready, !out_valid || out_ready);
      if (prev_hold) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", conv_out, prev_data);
      end
      if (out_valid && out_ready) begin
        checkOutput("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) checkOutput("conv_out", conv_out, exp_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_data = conv_out;
    end
  end

  task automatic applyStimulus(input logic [VW-1:0] img, input logic [VW-1:0] flt,
                               input logic f, input logic l, input logic m);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    image = img; filter = flt; first = f; last = l; signed_mode = m; in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(posedge clk);
      ok = in_ready;
      n++;
    end
    if (!ok) checkOutput("beat_accept_timeout", ok, 1);
    #1;
  endtask

  task automatic waitOutValid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) checkOutput(name, out_valid, 1);
  endtask

  initial begin
    logic [AW-1:0] neg_exp;
    rst_n = 1'b0; in_valid = 1'b0; image = '0; filter = '0;
    first = 1'b0; last = 1'b0; signed_mode = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_conv_out", conv_out, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat unsigned pixel and its three-cycle latency.
    applyStimulus(fill(8'd1), fill(8'd2), 1, 1, 0);
    in_valid = 1'b0;
    @(negedge clk); checkOutput("lat_n1_valid", out_valid, 0);
    @(negedge clk); checkOutput("lat_n2_valid", out_valid, 0);
    @(negedge clk); checkOutput("lat_n3_valid", out_valid, 1);
    checkOutput("unsigned_18", conv_out, 24'd18);

    // Signed -1 x 3 over nine lanes.
`ifdef CONV_CORE_RELU_EN
    neg_exp = 24'h000000;
`else
    neg_exp = 24'hFFFFE5;
`endif
    applyStimulus(fill(8'hFF), fill(8'd3), 1, 1, 1);
    in_valid = 1'b0;
    waitOutValid("signed_timeout");
    checkOutput("signed_neg27", conv_out, neg_exp);

    // Three back-to-back channels give one result.
    applyStimulus(fill(8'd1), fill(8'd2), 1, 0, 0);
    applyStimulus(fill(8'd1), fill(8'd2), 0, 0, 0);
    applyStimulus(fill(8'd1), fill(8'd2), 0, 1, 0);
    in_valid = 1'b0;
    waitOutValid("three_ch_timeout");
    checkOutput("three_ch_54", conv_out, 24'd54);
    @(negedge clk); checkOutput("three_ch_single", out_valid, 0);

    // Thirty max-unsigned channels wrap modulo 2^24.
    for (int c = 0; c < 30; c++)
      applyStimulus(fill(8'hFF), fill(8'hFF), c == 0, c == 29, 0);
    in_valid = 1'b0;
    waitOutValid("wrap_timeout");
    checkOutput("wrap_779534", conv_out, 24'd779534);

    // Backpressure: two results, downstream stalled for five cycles.
    ready_cmd = 1'b0;
    @(posedge clk); #3;
    applyStimulus(fill(8'd1), fill(8'd2), 1, 1, 0);
    applyStimulus(fill(8'd1), fill(8'd3), 1, 1, 0);
    in_valid = 1'b0;
    waitOutValid("stall_timeout");
    repeat (5) begin
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_hold_18", conv_out, 24'd18);
      @(negedge clk);
    end
    @(posedge clk); #1;
    ready_cmd = 1'b1;
    @(negedge clk);
    checkOutput("release_valid_a", out_valid, 1);
    checkOutput("release_18", conv_out, 24'd18);
    @(negedge clk);
    checkOutput("release_valid_b", out_valid, 1);
    checkOutput("release_27", conv_out, 24'd27);
    @(negedge clk);
    checkOutput("release_drained", out_valid, 0);

    // Reset in the middle of a three-channel pixel.
    applyStimulus(fill(8'd1), fill(8'd2), 1, 0, 0);
    applyStimulus(fill(8'd1), fill(8'd2), 0, 0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_conv_out", conv_out, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(fill(8'd1), fill(8'd2), 1, 1, 0);
    in_valid = 1'b0;
    waitOutValid("postrst_timeout");
    checkOutput("postrst_18", conv_out, 24'd18);

    // Random pixels, random gaps and random downstream throttling.
    rand_ready = 1'b1;
    for (int p = 0; p < 120; p++) begin
      int   nch;
      logic mode;
      logic [VW-1:0] ri;
      logic [VW-1:0] rf;
      nch  = $urandom_range(1, 4);
      mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < nch; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        for (int i = 0; i < N; i++) begin
          ri[i*DW +: DW] = DW'($urandom);
          rf[i*DW +: DW] = DW'($urandom);
        end
        applyStimulus(ri, rf, (c == 0) && ($urandom_range(0, 7) != 0), c == nch - 1, mode);
      end
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    ready_cmd  = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
